// File: rtl/clock_time_ctrl_pkg.sv
// Shared definitions for the wall-clock controller: mode encoding and default wrap limits.
package clock_time_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2
  } mode_e;

  localparam int SEC_MAX_DEF  = 59;
  localparam int MIN_MAX_DEF  = 59;
  localparam int HOUR_MAX_DEF = 23;

endpackage

// File: rtl/clock_time_ctrl_wrap_counter.sv
// Modulo-(MAX+1) counter; wrap is a combinational carry so counters can chain within one cycle.
module wrap_counter #(
  parameter int WIDTH = 6,
  parameter int MAX   = 59
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] value,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  assign wrap = en && (value == MAX_V);

  // clr wins over en so a mode exit can zero the count regardless of strobes
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (en) begin
      value <= wrap ? '0 : value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/clock_time_ctrl.sv
// HH:MM:SS clock with RUN / SET_HOUR / SET_MIN modes; carry pulses are registered and only raised by RUN-time wraps.
module clock_time_ctrl
  import clock_time_ctrl_pkg::*;
#(
  parameter int SEC_MAX  = SEC_MAX_DEF,
  parameter int MIN_MAX  = MIN_MAX_DEF,
  parameter int HOUR_MAX = HOUR_MAX_DEF
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic [1:0] mode,
  output logic       min_pulse,
  output logic       hour_pulse,
  output logic       day_pulse
);

  mode_e state;
  logic  in_run, in_set_hour, in_set_min, run_tick;
  logic  sec_en, sec_clr, min_en, hour_en;
  logic  sec_wrap, min_wrap, hour_wrap;

  assign in_run      = (state == MODE_RUN);
  assign in_set_hour = (state == MODE_SET_HOUR);
  assign in_set_min  = (state == MODE_SET_MIN);
  assign run_tick    = in_run && tick;

  // A simultaneous btn_mode suppresses btn_inc in the SET modes
  assign sec_en  = run_tick;
  assign sec_clr = in_set_min && btn_mode;
  assign min_en  = (run_tick && sec_wrap) || (in_set_min && btn_inc && !btn_mode);
  assign hour_en = (run_tick && sec_wrap && min_wrap) || (in_set_hour && btn_inc && !btn_mode);

  wrap_counter #(.WIDTH(6), .MAX(SEC_MAX)) u_sec (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (sec_en),
    .clr     (sec_clr),
    .value   (sec),
    .wrap    (sec_wrap)
  );

  wrap_counter #(.WIDTH(6), .MAX(MIN_MAX)) u_min (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (min_en),
    .clr     (1'b0),
    .value   (min),
    .wrap    (min_wrap)
  );

  wrap_counter #(.WIDTH(5), .MAX(HOUR_MAX)) u_hour (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (hour_en),
    .clr     (1'b0),
    .value   (hour),
    .wrap    (hour_wrap)
  );

  assign mode = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= MODE_RUN;
      min_pulse  <= 1'b0;
      hour_pulse <= 1'b0;
      day_pulse  <= 1'b0;
    end else begin
      min_pulse  <= run_tick && sec_wrap;
      hour_pulse <= run_tick && sec_wrap && min_wrap;
      day_pulse  <= run_tick && sec_wrap && min_wrap && hour_wrap;
      case (state)
        MODE_RUN:      if (btn_mode) state <= MODE_SET_HOUR;
        MODE_SET_HOUR: if (btn_mode) state <= MODE_SET_MIN;
        MODE_SET_MIN:  if (btn_mode) state <= MODE_RUN;
        default:       state <= MODE_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed bench for clock_time_ctrl: counting, carries, SET modes, button collisions and async reset.
module tb_clock_time_ctrl;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [5:0] sec, min;
  logic [4:0] hour;
  logic [1:0] mode;
  logic       min_pulse, hour_pulse, day_pulse;

  int compared = 0;
  int mismatched = 0;
  logic pulse_seen;

  clock_time_ctrl dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .tick       (tick),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .sec        (sec),
    .min        (min),
    .hour       (hour),
    .mode       (mode),
    .min_pulse  (min_pulse),
    .hour_pulse (hour_pulse),
    .day_pulse  (day_pulse)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s, input int md);
    check({tag, ".hour"}, 32'(hour), 32'(h));
    check({tag, ".min"},  32'(min),  32'(m));
    check({tag, ".sec"},  32'(sec),  32'(s));
    check({tag, ".mode"}, 32'(mode), 32'(md));
  endtask

  task automatic check_pulses(input string tag, input logic mp, input logic hp, input logic dp);
    check({tag, ".min_pulse"},  32'(min_pulse),  32'(mp));
    check({tag, ".hour_pulse"}, 32'(hour_pulse), 32'(hp));
    check({tag, ".day_pulse"},  32'(day_pulse),  32'(dp));
  endtask

  // One clock cycle with the given strobes; returns 1 time unit after the edge.
  task automatic step(input logic t, input logic m, input logic i);
    tick = t; btn_mode = m; btn_inc = i;
    @(posedge clock);
    #1;
    tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    if (min_pulse || hour_pulse || day_pulse) pulse_seen = 1'b1;
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    // Reset held from time 0: outputs must be zero before any clock edge
    #3;
    check_time("reset_pre_edge", 0, 0, 0, 0);
    check_pulses("reset_pre_edge", 0, 0, 0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    check_time("reset_release", 0, 0, 0, 0);

    // 60 ticks from 00:00:00 -> 00:01:00, min_pulse only after tick 60
    step(1, 0, 0);
    check_time("first_tick", 0, 0, 1, 0);
    for (int k = 2; k <= 59; k++) step(1, 0, 0);
    check_time("tick59", 0, 0, 59, 0);
    check_pulses("tick59", 0, 0, 0);
    step(1, 0, 0);
    check_time("tick60", 0, 1, 0, 0);
    check_pulses("tick60", 1, 0, 0);
    step(0, 0, 0);
    check_pulses("tick60_after", 0, 0, 0);

    // btn_inc ignored in RUN
    step(0, 0, 1);
    check_time("run_inc_ignored", 0, 1, 0, 0);

    // Fresh start, sec=17, then set hour via 25 increments (wraps past 23)
    do_reset();
    for (int k = 0; k < 17; k++) step(1, 0, 0);
    check_time("sec17", 0, 0, 17, 0);
    step(0, 1, 0);
    check_time("enter_set_hour", 0, 0, 17, 1);
    pulse_seen = 1'b0;
    for (int k = 0; k < 25; k++) step(0, 0, 1);
    check_time("hour_inc25", 1, 0, 17, 1);
    step(0, 1, 0);
    check_time("enter_set_min", 1, 0, 17, 2);
    for (int k = 0; k < 3; k++) step(0, 0, 1);
    check_time("min_inc3", 1, 3, 17, 2);
    for (int k = 0; k < 10; k++) step(1, 0, 0);
    check_time("set_min_ticks_ignored", 1, 3, 17, 2);
    check("set_no_pulses", 32'(pulse_seen), 32'(0));
    // Mode and inc together in SET_MIN: exit wins, sec cleared, min untouched
    step(0, 1, 1);
    check_time("exit_set_min", 1, 3, 0, 0);

    // Mode and inc together in RUN: enter SET_HOUR, hour unchanged
    step(0, 1, 1);
    check_time("run_mode_inc", 1, 3, 0, 1);

    // Preset 23:59:58
    for (int k = 0; k < 22; k++) step(0, 0, 1);
    step(0, 1, 0);
    for (int k = 0; k < 56; k++) step(0, 0, 1);
    check_time("preset_hm", 23, 59, 0, 2);
    step(0, 1, 0);
    for (int k = 0; k < 58; k++) step(1, 0, 0);
    check_time("preset_235958", 23, 59, 58, 0);
    step(1, 0, 0);
    check_time("t235959", 23, 59, 59, 0);
    check_pulses("t235959", 0, 0, 0);
    step(1, 0, 0);
    check_time("day_wrap", 0, 0, 0, 0);
    check_pulses("day_wrap", 1, 1, 1);
    step(0, 0, 0);
    check_pulses("day_wrap_after", 0, 0, 0);

    // Tick and mode together in RUN: tick applied and state moves
    step(1, 1, 0);
    check_time("run_tick_mode", 0, 0, 1, 1);

    // Back to RUN, build 12:34:05 in SET_MIN
    step(0, 1, 0);
    step(0, 1, 0);
    check_time("back_to_run", 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) step(1, 0, 0);
    step(0, 1, 0);
    for (int k = 0; k < 12; k++) step(0, 0, 1);
    step(0, 1, 0);
    for (int k = 0; k < 34; k++) step(0, 0, 1);
    check_time("preset_123405", 12, 34, 5, 2);

    // Async reset between edges while in SET_MIN
    #3 reset_n = 1'b0;
    #1;
    check_time("async_reset", 0, 0, 0, 0);
    check_pulses("async_reset", 0, 0, 0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    step(1, 0, 0);
    check_time("tick_after_reset", 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/clock_time_ctrl.md
CLOCK_TIME_CTRL -- requirements
Module: clock_time_ctrl

Interface
REQ-001 The block SHALL have parameter SEC_MAX, default 59, meaning the last seconds value before wrap.
REQ-002 The block SHALL have parameter MIN_MAX, default 59, meaning the last minutes value before wrap.
REQ-003 The block SHALL have parameter HOUR_MAX, default 23, meaning the last hours value before wrap.
REQ-004 The block SHALL have port clock  input  1  the single clock; all state changes occur on its rising edge.
REQ-005 The block SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port tick  input  1  one-cycle 1 Hz advance strobe.
REQ-007 The block SHALL have port btn_mode  input  1  one-cycle debounced mode-button pulse.
REQ-008 The block SHALL have port btn_inc  input  1  one-cycle debounced increment-button pulse.
REQ-009 The block SHALL have port sec  output  6  current seconds, 0..SEC_MAX.
REQ-010 The block SHALL have port min  output  6  current minutes, 0..MIN_MAX.
REQ-011 The block SHALL have port hour  output  5  current hours, 0..HOUR_MAX.
REQ-012 The block SHALL have port mode  output  2  FSM state: 0 RUN, 1 SET_HOUR, 2 SET_MIN.
REQ-013 The block SHALL have port min_pulse  output  1  one-cycle pulse when seconds wrap in RUN.
REQ-014 The block SHALL have port hour_pulse  output  1  one-cycle pulse when minutes wrap in RUN.
REQ-015 The block SHALL have port day_pulse  output  1  one-cycle pulse when hours wrap in RUN.

Function
REQ-016 The FSM SHALL have states RUN, SET_HOUR and SET_MIN, with transitions on btn_mode: RUN->SET_HOUR->SET_MIN->RUN; mode value 3 SHALL never occur and, if reached, SHALL return to RUN on the next edge.
REQ-017 In RUN, on a cycle where tick=1, sec SHALL increment by 1 at that edge (one-cycle latency, registered output).
REQ-018 When tick=1 and sec==SEC_MAX, sec SHALL become 0, min SHALL increment, and min_pulse SHALL be 1 for exactly the following cycle.
REQ-019 When additionally min==MIN_MAX, min SHALL become 0, hour SHALL increment, and hour_pulse SHALL be 1 in the same cycle as min_pulse.
REQ-020 When additionally hour==HOUR_MAX, hour SHALL become 0, and day_pulse SHALL be 1 in the same cycle as min_pulse and hour_pulse.
REQ-021 In SET_HOUR and SET_MIN, tick SHALL be ignored and sec SHALL hold its value.
REQ-022 In SET_HOUR, btn_inc SHALL increment hour, wrapping HOUR_MAX->0 with no carry and no pulses; in SET_MIN, btn_inc SHALL increment min, wrapping MIN_MAX->0 with no carry and no pulses.
REQ-023 In RUN, btn_inc SHALL be ignored.
REQ-024 On the SET_MIN->RUN transition, sec SHALL be cleared to 0 at that edge.
REQ-025 When btn_mode and btn_inc are asserted in the same cycle, the mode change SHALL take effect and btn_inc SHALL be ignored.
REQ-026 When btn_mode and tick are asserted in the same cycle in RUN, the tick SHALL be applied and the state SHALL move to SET_HOUR at the same edge.
REQ-027 min_pulse, hour_pulse and day_pulse SHALL be registered outputs and SHALL never be asserted outside RUN-caused wraps.

Reset
REQ-028 While reset_n=0, sec, min, hour SHALL be 0, mode SHALL be RUN, and all pulses SHALL be 0, independently of clock.
REQ-029 Reset asserted mid-operation, including in a SET state, SHALL abort to RUN with 00:00:00; the first tick after reset_n rises SHALL yield sec=1.

Structure
REQ-030 A shared package SHALL hold the mode state encoding (RUN/SET_HOUR/SET_MIN) and the default wrap constants 59/59/23.
REQ-031 One sub-module, wrap_counter (parameters WIDTH and MAX; inputs en, reset_n; outputs value and wrap), SHALL be instantiated three times for sec, min and hour.

Verification
REQ-032 The bench SHALL cover: reset, then 60 ticks -> sec=0, min=1, with min_pulse high exactly one cycle after tick 60.
REQ-033 The bench SHALL cover: preset 23:59:58 via SET mode, then 2 ticks -> 00:00:00 after the second tick, with min_pulse, hour_pulse and day_pulse coincident for one cycle.
REQ-034 The bench SHALL cover: btn_mode, then btn_inc x25 in SET_HOUR -> hour=1 (wrap at 24, no day_pulse); btn_mode, btn_inc x3 -> min=3; btn_mode -> RUN with sec=0.
REQ-035 The bench SHALL cover: in SET_MIN with sec=17, apply 10 ticks -> sec stays 17 until exit, then sec=0.
REQ-036 The bench SHALL cover: btn_mode and btn_inc in the same cycle from RUN -> mode=SET_HOUR and hour unchanged.
REQ-037 The bench SHALL cover: reset_n pulsed low asynchronously between edges while in SET_MIN at 12:34:05 -> outputs 00:00:00, mode RUN, immediately.
